fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage for YASAC. It sits between the program counter logic and the decoder.
- Drives the code memory address port and captures the 16-bit instruction word returned combinationally in the same cycle.
- Buffers fetched words in a 2-entry prefetch queue and hands them to decode over a valid/ready handshake.
- Handles redirects (taken branches/jumps) by flushing and refetching.

Parameters:
- AW, 8, code address width (256-word code space)
- DW, 16, instruction word width
- QDEPTH, 2, prefetch queue depth (only 2 is required to be supported)

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset
- code_addr  out  AW  address to code memory (combinational copy of fetch_pc)
- code_data  in  DW  instruction word from code memory, valid in the same cycle
- ir  out  DW  instruction at the queue head; 0 when the queue is empty
- ir_pc  out  AW  address of ir; 0 when the queue is empty
- ir_valid  out  1  queue head holds a valid instruction
- ir_ready  in  1  decoder accepts ir this cycle
- redirect  in  1  flush and restart fetch at redirect_addr
- redirect_addr  in  AW  new fetch address
- halt  in  1  suspend fetching (queue still drains)
- q_count  out  2  number of valid queue entries, 0..2

Interface: one clock; reset is asynchronous and active-low. All state updates on the rising clk edge.

Behaviour:
- State: fetch_pc (AW), queue entries {pc, instr} x2, rd_ptr, wr_ptr, count.
- Reset (reset_n=0, immediate, independent of clk):
  - fetch_pc=0, count=0, pointers=0.
  - ir_valid=0, ir=0, ir_pc=0, q_count=0, code_addr=0.
- pop = ir_valid & ir_ready.
- push = !halt & !redirect & (count<2 | pop).
  - Pushing when the queue is full with a simultaneous pop is legal; count stays 2.
- On push:
  - The entry {fetch_pc, code_data} is written at wr_ptr.
  - fetch_pc <= fetch_pc+1 modulo 2^AW; 255 wraps to 0, with no flag.
- On pop: rd_ptr advances.
- count update: +1 on push only; -1 on pop only; unchanged on both or neither.
- Redirect has highest priority over push and pop:
  - Queue is flushed (count=0, pointers=0) and fetch_pc <= redirect_addr.
  - A pop asserted in the same cycle is ignored: the decoder must not consume ir during a redirect.
  - ir_valid is 0 in the following cycle.
  - The target instruction is pushed on the next edge if halt=0.
  - Redirect-to-valid latency: 2 edges.
- Latency:
  - After reset release, the first edge pushes addr 0; ir_valid=1 after edge 1.
  - The queue fills after edge 2 if ir_ready stays 0.
  - Steady state: 1 instruction/cycle when ir_ready is held 1.
- Halt:
  - No push, fetch_pc frozen; the queue drains normally.
  - halt+redirect: fetch_pc loads redirect_addr, queue flushes, no fetch until halt=0.
- Outputs:
  - ir and ir_pc come from the head entry via a mux on rd_ptr; forced to 0 when count=0.
  - ir_valid = (count!=0).
- No combinational path from ir_ready or redirect to code_addr; code_addr depends only on fetch_pc.

Decomposition:
- globals.vh holds the shared constants:
  - instruction field positions: opcode[15:11], Ra/s[10:8], k[7:0], Rb[2:0]
  - AW/DW defaults
  - NOP encoding 16'h0000
- Sub-module fetch_queue: the 2-entry synchronous FIFO with push, pop, flush, count, head outputs.
  - Async active-low reset.
  - flush has priority over push/pop.
- The fetch_unit top holds fetch_pc, push/pop/redirect arbitration and the output forcing.

Test Plan:
- Reset and stall: memory word at addr n = 16'h1000+n, ir_ready=0, release reset_n → after edge 1: ir=16'h1000, ir_pc=0, ir_valid=1, q_count=1; after edge 2: q_count=2, code_addr=2, then stable.
- Streaming: ir_ready=1 held after reset → ir_pc sequence 0,1,2,3…, one per cycle, no gaps; q_count stays 1.
- Wrap-around: redirect_addr=8'hFE, ir_ready=1 → ir_pc sequence FE, FF, 00, 01.
- Redirect with full queue and ready: q_count=2, redirect=1, redirect_addr=8'h40, ir_ready=1 in the same cycle → next cycle ir_valid=0, q_count=0 (the pop is ignored); following cycle ir_pc=8'h40, ir=16'h1040.
- Halt drain: queue full, halt=1, ir_ready=1 for 3 cycles → q_count 2→1→0, code_addr unchanged throughout; deassert halt → fetch resumes at the held address.
- Asynchronous reset mid-stream: pull reset_n low between edges while ir_valid=1 → ir_valid, q_count and code_addr go to 0 immediately, without waiting for an edge.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared constants for the YASAC fetch stage
package fetch_unit_pkg;

    localparam int AW_DEF     = 8;
    localparam int DW_DEF     = 16;
    localparam int QDEPTH_DEF = 2;

    // Instruction field positions as seen by the decoder.
    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 11;
    localparam int RA_MSB     = 10;
    localparam int RA_LSB     = 8;
    localparam int K_MSB      = 7;
    localparam int K_LSB      = 0;
    localparam int RB_MSB     = 2;
    localparam int RB_LSB     = 0;

    localparam logic [15:0] NOP_INSTR = 16'h0000;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - 2-entry prefetch FIFO holding {pc, instr}, flush beats push/pop
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] push_pc,
    input  logic [DW-1:0] push_instr,
    output logic [AW-1:0] head_pc,
    output logic [DW-1:0] head_instr,
    output logic [1:0]    count
);

    logic [AW-1:0] pc_mem    [2];
    logic [DW-1:0] instr_mem [2];
    logic          rd_ptr;
    logic          wr_ptr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_mem[0]    <= '0;
            pc_mem[1]    <= '0;
            instr_mem[0] <= '0;
            instr_mem[1] <= '0;
        end else if (!flush && push) begin
            pc_mem[wr_ptr]    <= push_pc;
            instr_mem[wr_ptr] <= push_instr;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head_pc    = pc_mem[rd_ptr];
    assign head_instr = instr_mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - YASAC instruction fetch: fetch_pc, push/pop/redirect arbitration, output forcing
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int AW     = AW_DEF,
    parameter int DW     = DW_DEF,
    parameter int QDEPTH = QDEPTH_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    output logic [AW-1:0] code_addr,
    input  logic [DW-1:0] code_data,
    output logic [DW-1:0] ir,
    output logic [AW-1:0] ir_pc,
    output logic          ir_valid,
    input  logic          ir_ready,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_addr,
    input  logic          halt,
    output logic [1:0]    q_count
);

    logic [AW-1:0] fetch_pc;
    logic [AW-1:0] head_pc;
    logic [DW-1:0] head_instr;
    logic [1:0]    count;
    logic          pop;
    logic          push;
    logic          full;

    assign full     = (count == 2'(QDEPTH));
    assign ir_valid = (count != 2'd0);
    assign pop      = ir_valid && ir_ready;
    // A pop during redirect is harmless: the queue's flush overrides it.
    assign push     = !halt && !redirect && (!full || pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc <= '0;
        end else if (redirect) begin
            fetch_pc <= redirect_addr;
        end else if (push) begin
            fetch_pc <= fetch_pc + AW'(1);
        end
    end

    fetch_queue #(
        .AW(AW),
        .DW(DW)
    ) u_queue (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (redirect),
        .push       (push),
        .pop        (pop),
        .push_pc    (fetch_pc),
        .push_instr (code_data),
        .head_pc    (head_pc),
        .head_instr (head_instr),
        .count      (count)
    );

    assign code_addr = fetch_pc;
    assign q_count   = count;
    assign ir        = ir_valid ? head_instr : DW'(NOP_INSTR);
    assign ir_pc     = ir_valid ? head_pc : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic [7:0]  code_addr;
    logic [15:0] code_data;
    logic [15:0] ir;
    logic [7:0]  ir_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic        redirect;
    logic [7:0]  redirect_addr;
    logic        halt;
    logic [1:0]  q_count;

    int checks_total;
    int checks_passed;

    fetch_unit dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .code_addr     (code_addr),
        .code_data     (code_data),
        .ir            (ir),
        .ir_pc         (ir_pc),
        .ir_valid      (ir_valid),
        .ir_ready      (ir_ready),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .halt          (halt),
        .q_count       (q_count)
    );

    // Code memory: word at address n is 16'h1000 + n.
    assign code_data = 16'h1000 + {8'h00, code_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks_total++;
        if (got === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        reset_n       = 1'b0;
        ir_ready      = 1'b0;
        redirect      = 1'b0;
        redirect_addr = 8'h00;
        halt          = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_valid", 16'(ir_valid), 16'h0);
        check("rst_count", 16'(q_count), 16'h0);
        check("rst_addr", 16'(code_addr), 16'h0);
        check("rst_ir", ir, 16'h0);
        check("rst_ir_pc", 16'(ir_pc), 16'h0);

        // Reset release with decoder stalled
        reset_n = 1'b1;
        step();
        check("stall1_ir", ir, 16'h1000);
        check("stall1_ir_pc", 16'(ir_pc), 16'h0);
        check("stall1_valid", 16'(ir_valid), 16'h1);
        check("stall1_count", 16'(q_count), 16'h1);
        step();
        check("stall2_count", 16'(q_count), 16'h2);
        check("stall2_addr", 16'(code_addr), 16'h2);
        step();
        check("stall3_count", 16'(q_count), 16'h2);
        check("stall3_addr", 16'(code_addr), 16'h2);
        check("stall3_ir_pc", 16'(ir_pc), 16'h0);

        // Redirect with full queue and decoder ready: pop ignored
        redirect      = 1'b1;
        redirect_addr = 8'h40;
        ir_ready      = 1'b1;
        step();
        check("redir_valid", 16'(ir_valid), 16'h0);
        check("redir_count", 16'(q_count), 16'h0);
        check("redir_addr", 16'(code_addr), 16'h40);
        redirect = 1'b0;
        ir_ready = 1'b0;
        step();
        check("redir_ir_pc", 16'(ir_pc), 16'h40);
        check("redir_ir", ir, 16'h1040);
        check("redir_count1", 16'(q_count), 16'h1);

        // Streaming from the redirect target
        ir_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            check("stream_ir_pc", 16'(ir_pc), 16'(8'h40 + 8'(i)));
            check("stream_count", 16'(q_count), 16'h1);
        end

        // Wrap-around of fetch_pc
        redirect      = 1'b1;
        redirect_addr = 8'hFE;
        step();
        check("wrap_flush", 16'(ir_valid), 16'h0);
        redirect = 1'b0;
        begin
            logic [7:0] wrap_pc [4];
            wrap_pc[0] = 8'hFE;
            wrap_pc[1] = 8'hFF;
            wrap_pc[2] = 8'h00;
            wrap_pc[3] = 8'h01;
            for (int i = 0; i < 4; i++) begin
                step();
                check("wrap_ir_pc", 16'(ir_pc), 16'(wrap_pc[i]));
                check("wrap_ir", ir, 16'h1000 + {8'h00, wrap_pc[i]});
            end
        end

        // Fill, then halt and drain
        ir_ready = 1'b0;
        step();
        check("fill_count", 16'(q_count), 16'h2);
        check("fill_addr", 16'(code_addr), 16'h3);
        halt     = 1'b1;
        ir_ready = 1'b1;
        step();
        check("drain1_count", 16'(q_count), 16'h1);
        check("drain1_ir_pc", 16'(ir_pc), 16'h2);
        check("drain1_addr", 16'(code_addr), 16'h3);
        step();
        check("drain2_count", 16'(q_count), 16'h0);
        check("drain2_ir", ir, 16'h0);
        check("drain2_addr", 16'(code_addr), 16'h3);
        step();
        check("drain3_count", 16'(q_count), 16'h0);
        check("drain3_addr", 16'(code_addr), 16'h3);
        halt     = 1'b0;
        ir_ready = 1'b0;
        step();
        check("resume_ir_pc", 16'(ir_pc), 16'h3);
        check("resume_count", 16'(q_count), 16'h1);

        // Halt with redirect: load target, no fetch until halt drops
        halt          = 1'b1;
        redirect      = 1'b1;
        redirect_addr = 8'h80;
        step();
        check("hredir_count", 16'(q_count), 16'h0);
        check("hredir_addr", 16'(code_addr), 16'h80);
        redirect = 1'b0;
        step();
        check("hredir_hold_count", 16'(q_count), 16'h0);
        check("hredir_hold_addr", 16'(code_addr), 16'h80);
        halt = 1'b0;
        step();
        check("hredir_ir_pc", 16'(ir_pc), 16'h80);
        check("hredir_ir", ir, 16'h1080);

        // Asynchronous reset between edges
        check("pre_arst_valid", 16'(ir_valid), 16'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_valid", 16'(ir_valid), 16'h0);
        check("arst_count", 16'(q_count), 16'h0);
        check("arst_addr", 16'(code_addr), 16'h0);
        @(negedge clk);

        // Streaming straight out of reset
        reset_n  = 1'b1;
        ir_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("rs_stream_ir_pc", 16'(ir_pc), 16'(i));
            check("rs_stream_count", 16'(q_count), 16'h1);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
